// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter in front of a single
// AXI4-Lite UART transmitter. Each accepted byte becomes exactly one AXI
// write (AW, then W, then B), and a grant is held for a whole packet or
// until MAX_PKT bytes have been sent.
// Optional feature macro: UART_ARB_PREFIX_EN -- when defined, every grant
// first emits an ASCII '0'+grant_id byte ahead of the packet.
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter logic [31:0] UART_ADDR = 32'h0,
    parameter int          MAX_PKT   = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic [31:0]          m_awaddr,
    output logic [2:0]           m_awprot,
    output logic                 m_wvalid,
    input  logic                 m_wready,
    output logic [31:0]          m_wdata,
    output logic [3:0]           m_wstrb,
    input  logic                 m_bvalid,
    output logic                 m_bready
);

    localparam int CNT_W = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

`ifdef UART_ARB_PREFIX_EN
    typedef enum logic [2:0] {IDLE, LOAD, AW, W, B, PREFIX} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, AW, W, B} state_t;
`endif

    state_t             state;
    state_t             next_state;
    logic [2:0]         ptr;
    logic [CNT_W-1:0]   count;
    logic [7:0]         byte_q;
    logic               last_q;
    logic [2:0]         sel;
    logic               found;
    logic               any_valid;
    logic               gnt_valid;
    logic [7:0]         gnt_data;
    logic               gnt_last;
    logic               pkt_done;
`ifdef UART_ARB_PREFIX_EN
    logic               pfx_q;
`endif

    assign m_awaddr = UART_ADDR;
    assign m_awprot = 3'b000;
    assign m_wstrb  = 4'b0001;
    assign m_wdata  = {24'b0, byte_q};
    assign busy     = (state != IDLE);
    assign pkt_done = last_q || (count == CNT_W'(MAX_PKT - 1));

    // Round-robin search: first valid requester after ptr, wrapping.
    always_comb begin
        any_valid = |req_valid;
        sel       = ptr;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                sel   = 3'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    // Select the stream of the currently granted requester.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = 8'h00;
        gnt_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                gnt_valid = req_valid[i];
                gnt_data  = req_data[8*i +: 8];
                gnt_last  = req_last[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state and handshake outputs; AW and W are never raised together.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (state)
            IDLE: begin
`ifdef UART_ARB_PREFIX_EN
                if (any_valid) next_state = PREFIX;
`else
                if (any_valid) next_state = LOAD;
`endif
            end
`ifdef UART_ARB_PREFIX_EN
            PREFIX: next_state = AW;
`endif
            LOAD: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_id == 3'(i));
                end
                if (gnt_valid) next_state = AW;
            end
            AW: begin
                m_awvalid = 1'b1;
                if (m_awready) next_state = W;
            end
            W: begin
                m_wvalid = 1'b1;
                if (m_wready) next_state = B;
            end
            B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
`ifdef UART_ARB_PREFIX_EN
                    if (pfx_q)         next_state = LOAD;
                    else if (pkt_done) next_state = IDLE;
                    else               next_state = LOAD;
`else
                    if (pkt_done) next_state = IDLE;
                    else          next_state = LOAD;
`endif
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant, round-robin pointer and per-grant byte count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant_id <= 3'd0;
            ptr      <= 3'(NUM_REQ - 1);
            count    <= '0;
`ifdef UART_ARB_PREFIX_EN
            pfx_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= sel;
                        count    <= '0;
`ifdef UART_ARB_PREFIX_EN
                        pfx_q    <= 1'b1;
`endif
                    end
                end
                B: begin
                    if (m_bvalid) begin
`ifdef UART_ARB_PREFIX_EN
                        if (pfx_q)         pfx_q <= 1'b0;
                        else if (pkt_done) ptr   <= grant_id;
                        else               count <= count + 1'b1;
`else
                        if (pkt_done) ptr   <= grant_id;
                        else          count <= count + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte under transfer; only loaded when a write is about to start.
    always_ff @(posedge clk) begin
        if (state == LOAD && gnt_valid) begin
            byte_q <= gnt_data;
            last_q <= gnt_last;
        end
`ifdef UART_ARB_PREFIX_EN
        else if (state == PREFIX) begin
            byte_q <= 8'h30 + {5'b0, grant_id};
            last_q <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a byte-source
// model per requester and a stallable AXI4-Lite slave that logs writes.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_PREFIX_EN
    localparam bit PFX = 1'b1;
`else
    localparam bit PFX = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic [31:0] rd;
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic [3:0]  req_ready;
    logic [2:0]  grant_id;
    logic        busy;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_wvalid;
    logic        m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid;
    logic        m_bready;

    uart_tx_arbiter #(.NUM_REQ(4), .UART_ADDR(32'h0), .MAX_PKT(64)) dut (
        .clk(clk), .resetn(resetn),
        .req_data(rd), .req_valid(rv), .req_last(rl), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awprot(m_awprot), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester byte queues {last, data}
    logic [8:0] rmem [0:3][0:127];
    int         rhead [0:3];
    int         rtail [0:3];
    logic [3:0] hs_pend;

    // slave model and write log
    int         aw_stall, w_stall, aw_cnt, w_cnt;
    logic [7:0] wlog [0:255];
    int         wcnt;
    int         aw_cyc, w_cyc;
    int         lat_err, hold_err, overlap_err, unsel_err, fmt_err;
    logic       aw_pend_prev, w_pend_prev, rst_prev;
    logic [31:0] wdata_prev;

    logic [7:0] exp_q [0:255];
    int         exp_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b, input logic last);
        rmem[id][rtail[id]] = {last, b};
        rtail[id]++;
    endtask

    task automatic exp_grant(input int id);
        if (PFX) begin
            exp_q[exp_n] = 8'h30 + 8'(id);
            exp_n++;
        end
    endtask

    task automatic exp_add(input logic [7:0] b);
        exp_q[exp_n] = b;
        exp_n++;
    endtask

    task automatic clear_env();
        for (int i = 0; i < 4; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        hs_pend = '0;
        wcnt = 0; exp_n = 0; aw_cyc = 0; w_cyc = 0;
        lat_err = 0; hold_err = 0; overlap_err = 0; unsel_err = 0; fmt_err = 0;
        aw_stall = 0; w_stall = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        clear_env();
        resetn = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int c;
        c = 0;
        while (wcnt < n && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nwr"}, wcnt, exp_n);
        for (int i = 0; i < exp_n && i < wcnt; i++)
            check($sformatf("%s_b%0d", tag, i), {24'b0, wlog[i]}, {24'b0, exp_q[i]});
        check({tag, "_lat"}, lat_err, 0);
        check({tag, "_fmt"}, fmt_err, 0);
        check({tag, "_unsel"}, unsel_err, 0);
        check({tag, "_ovl"}, overlap_err, 0);
    endtask

    // Environment: byte sources, AXI slave, protocol monitors (negedge).
    initial begin
        aw_cnt = 0; w_cnt = 0; rst_prev = 1'b1;
        aw_pend_prev = 1'b0; w_pend_prev = 1'b0; wdata_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_prev && hs_pend != 4'b0 && !m_awvalid) lat_err++;
            for (int i = 0; i < 4; i++)
                if (hs_pend[i]) rhead[i]++;
            for (int i = 0; i < 4; i++) begin
                if (rhead[i] < rtail[i]) begin
                    rv[i] = 1'b1;
                    rl[i] = rmem[i][rhead[i]][8];
                    rd[8*i +: 8] = rmem[i][rhead[i]][7:0];
                end else begin
                    rv[i] = 1'b0;
                    rl[i] = 1'b0;
                    rd[8*i +: 8] = 8'h00;
                end
            end
            m_awready = m_awvalid && (aw_cnt >= aw_stall);
            aw_cnt    = m_awvalid ? aw_cnt + 1 : 0;
            m_wready  = m_wvalid && (w_cnt >= w_stall);
            w_cnt     = m_wvalid ? w_cnt + 1 : 0;
            m_bvalid  = m_bready;
            if (m_awvalid) aw_cyc++;
            if (m_wvalid)  w_cyc++;
            if (m_awvalid && m_awready && (m_awaddr != 32'h0 || m_awprot != 3'b000)) fmt_err++;
            if (m_wvalid && m_wready) begin
                if (m_wdata[31:8] != 24'h0 || m_wstrb != 4'b0001) fmt_err++;
                wlog[wcnt] = m_wdata[7:0];
                wcnt++;
            end
            if (m_awvalid && m_wvalid) overlap_err++;
            for (int i = 0; i < 4; i++)
                if (req_ready[i] && 3'(i) != grant_id) unsel_err++;
            if (req_ready != 4'b0 && !busy) unsel_err++;
            if (!rst_prev) begin
                if (aw_pend_prev && !m_awvalid) hold_err++;
                if (w_pend_prev && (!m_wvalid || m_wdata != wdata_prev)) hold_err++;
            end
            aw_pend_prev = m_awvalid && !m_awready;
            w_pend_prev  = m_wvalid && !m_wready;
            wdata_prev   = m_wdata;
            rst_prev     = !resetn;
            hs_pend      = resetn ? (rv & req_ready) : 4'b0;
        end
    end

    initial begin
        bit reached;
        int c;
        resetn = 1'b0;
        rv = '0; rl = '0; rd = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        clear_env();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        #1;
        clear_env();
        resetn = 1'b1;

        // single requester, three bytes
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        exp_grant(0); exp_add(8'h41); exp_add(8'h42); exp_add(8'h43);
        wait_writes(exp_n, 200);
        compare_log("t1");
        check("t1_busy", busy, 0);
        check("t1_grant", grant_id, 0);

        // two requesters from reset pointer: 1 then 2, no interleave
        do_reset();
        push(1, 8'h11, 0); push(1, 8'h12, 1);
        push(2, 8'h21, 0); push(2, 8'h22, 1);
        exp_grant(1); exp_add(8'h11); exp_add(8'h12);
        exp_grant(2); exp_add(8'h21); exp_add(8'h22);
        wait_writes(exp_n, 200);
        compare_log("t2");
        check("t2_grant", grant_id, 2);
        check("t2_busy", busy, 0);

        // forced release after 64 bytes, requester 3 gets its turn
        do_reset();
        for (int i = 0; i < 70; i++) push(0, 8'(i), 0);
        push(3, 8'hA0, 0); push(3, 8'hA1, 1);
        exp_grant(0);
        for (int i = 0; i < 64; i++) exp_add(8'(i));
        exp_grant(3); exp_add(8'hA0); exp_add(8'hA1);
        exp_grant(0);
        for (int i = 64; i < 70; i++) exp_add(8'(i));
        wait_writes(exp_n, 3000);
        compare_log("t3");
        check("t3_busy", busy, 1);
        check("t3_grant", grant_id, 0);
        check("t3_ready", req_ready, 4'b0001);

        // slave stalls: valids held, one write per byte
        do_reset();
        aw_stall = 5; w_stall = 3;
        push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
        exp_grant(1); exp_add(8'h51); exp_add(8'h52); exp_add(8'h53);
        wait_writes(exp_n, 500);
        compare_log("t4");
        check("t4_hold", hold_err, 0);
        check("t4_awcyc", aw_cyc, exp_n * 6);
        check("t4_wcyc", w_cyc, exp_n * 4);
        check("t4_busy", busy, 0);

        // reset while in W, then a normal packet
        do_reset();
        w_stall = 3;
        push(2, 8'h61, 1);
        reached = 1'b0;
        c = 0;
        while (!reached && c < 200) begin
            @(posedge clk);
            #2;
            reached = m_wvalid && (m_wdata[7:0] == 8'h61);
            c++;
        end
        check("t5_reach", reached, 1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("t5_wvalid", m_wvalid, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", req_ready, 0);
        check("t5_grant", grant_id, 0);
        resetn = 1'b1;
        clear_env();
        push(2, 8'h62, 1);
        exp_grant(2); exp_add(8'h62);
        wait_writes(exp_n, 200);
        compare_log("t5");
        check("t5_busy_end", busy, 0);

        // requester 2 sends 'x'
        do_reset();
        push(2, 8'h78, 1);
        exp_grant(2); exp_add(8'h78);
        wait_writes(exp_n, 200);
        compare_log("t6");
        check("t6_grant", grant_id, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
